// File: rtl/pacman_move_ctrl.sv
// Per-frame sprite motion sequencer for the maze game.
// Latches WASD, probes the wall unit (turn first, then ahead), then steps.
module pacman_move_ctrl #(
    parameter int unsigned X_START = 320,
    parameter int unsigned Y_START = 240,
    parameter int unsigned STEP    = 1,
    parameter int unsigned X_MIN   = 4,
    parameter int unsigned X_MAX   = 635,
    parameter int unsigned Y_MIN   = 4,
    parameter int unsigned Y_MAX   = 475,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       tick,
    input  logic [7:0] keycode,
    output logic       wall_req,
    output logic [9:0] wall_x,
    output logic [9:0] wall_y,
    input  logic       wall_ack,
    input  logic       wall_blocked,
    output logic [9:0] PosX,
    output logic [9:0] PosY,
    output logic [1:0] dir,
    output logic       moving,
    output logic       overrun
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [10:0] STEP11 = 11'(STEP);
    localparam logic [9:0]  STEP10 = 10'(STEP);
    localparam logic [10:0] XMIN11 = 11'(X_MIN);
    localparam logic [10:0] XMAX11 = 11'(X_MAX);
    localparam logic [10:0] YMIN11 = 11'(Y_MIN);
    localparam logic [10:0] YMAX11 = 11'(Y_MAX);

    localparam logic [1:0] D_UP    = 2'd0;
    localparam logic [1:0] D_LEFT  = 2'd1;
    localparam logic [1:0] D_DOWN  = 2'd2;
    localparam logic [1:0] D_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        CHK_TURN,
        CHK_FWD,
        MOVE
    } state_t;

    state_t        state_q;
    logic [9:0]    pos_x_q;
    logic [9:0]    pos_y_q;
    logic [9:0]    wall_x_q;
    logic [9:0]    wall_y_q;
    logic [1:0]    dir_q;
    logic [1:0]    probe_dir_q;
    logic [1:0]    pend_dir_q;
    logic          pend_valid_q;
    logic          moving_q;
    logic          req_q;
    logic          overrun_q;
    logic [CW-1:0] cnt_q;

    logic       key_hit;
    logic [1:0] key_dir;
    logic       eff_pv;
    logic [1:0] eff_pd;

    always_comb begin
        key_hit = 1'b1;
        key_dir = D_UP;
        unique case (1'b1)
            (keycode == 8'h1a): key_dir = D_UP;
            (keycode == 8'h04): key_dir = D_LEFT;
            (keycode == 8'h16): key_dir = D_DOWN;
            (keycode == 8'h07): key_dir = D_RIGHT;
            default:            key_hit = 1'b0;
        endcase
    end

    // A key arriving with the tick takes effect for that same frame.
    assign eff_pv = pend_valid_q | key_hit;
    assign eff_pd = key_hit ? key_dir : pend_dir_q;

    logic [10:0] probe_x11;
    logic [10:0] probe_y11;
    logic        in_range;

    // 11-bit math so a step below zero lands far above the max bound.
    always_comb begin
        probe_x11 = {1'b0, pos_x_q};
        probe_y11 = {1'b0, pos_y_q};
        case (probe_dir_q)
            D_UP:    probe_y11 = {1'b0, pos_y_q} - STEP11;
            D_LEFT:  probe_x11 = {1'b0, pos_x_q} - STEP11;
            D_DOWN:  probe_y11 = {1'b0, pos_y_q} + STEP11;
            default: probe_x11 = {1'b0, pos_x_q} + STEP11;
        endcase
        in_range = (probe_x11 >= XMIN11) && (probe_x11 <= XMAX11) &&
                   (probe_y11 >= YMIN11) && (probe_y11 <= YMAX11);
    end

    logic [9:0] step_x_d;
    logic [9:0] step_y_d;

    always_comb begin
        step_x_d = pos_x_q;
        step_y_d = pos_y_q;
        case (dir_q)
            D_UP:    step_y_d = pos_y_q - STEP10;
            D_LEFT:  step_x_d = pos_x_q - STEP10;
            D_DOWN:  step_y_d = pos_y_q + STEP10;
            default: step_x_d = pos_x_q + STEP10;
        endcase
    end

    logic in_chk;
    logic ack_ok;
    logic timed_out;
    logic probe_done;
    logic probe_clear;

    assign in_chk      = (state_q == CHK_TURN) || (state_q == CHK_FWD);
    assign ack_ok      = req_q && wall_ack;
    assign timed_out   = req_q && !wall_ack && (cnt_q == CNT_LAST);
    assign probe_done  = in_chk &&
                         ((!req_q && !in_range) || ack_ok || timed_out);
    assign probe_clear = ack_ok && !wall_blocked;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            pos_x_q      <= 10'(X_START);
            pos_y_q      <= 10'(Y_START);
            wall_x_q     <= '0;
            wall_y_q     <= '0;
            dir_q        <= D_UP;
            probe_dir_q  <= D_UP;
            pend_dir_q   <= D_UP;
            pend_valid_q <= 1'b0;
            moving_q     <= 1'b0;
            req_q        <= 1'b0;
            overrun_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            overrun_q <= tick && (state_q != IDLE);
            if (key_hit) begin
                pend_dir_q   <= key_dir;
                pend_valid_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (tick) begin
                        if (eff_pv && (!moving_q || eff_pd != dir_q)) begin
                            state_q     <= CHK_TURN;
                            probe_dir_q <= eff_pd;
                        end else if (moving_q) begin
                            state_q     <= CHK_FWD;
                            probe_dir_q <= dir_q;
                        end
                    end
                end
                CHK_TURN, CHK_FWD: begin
                    // First cycle in a CHK state has req_q low.
                    if (!req_q && in_range) begin
                        req_q    <= 1'b1;
                        wall_x_q <= probe_x11[9:0];
                        wall_y_q <= probe_y11[9:0];
                        cnt_q    <= '0;
                    end else if (req_q && !probe_done) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (probe_done) begin
                        req_q <= 1'b0;
                        if (probe_clear) begin
                            state_q <= MOVE;
                            if (state_q == CHK_TURN) begin
                                dir_q    <= probe_dir_q;
                                moving_q <= 1'b1;
                                if (!key_hit && pend_dir_q == probe_dir_q)
                                    pend_valid_q <= 1'b0;
                            end
                        end else if (state_q == CHK_TURN && moving_q) begin
                            state_q     <= CHK_FWD;
                            probe_dir_q <= dir_q;
                        end else begin
                            state_q <= IDLE;
                            if (state_q == CHK_FWD)
                                moving_q <= 1'b0;
                        end
                    end
                end
                MOVE: begin
                    pos_x_q <= step_x_d;
                    pos_y_q <= step_y_d;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wall_req = req_q;
    assign wall_x   = wall_x_q;
    assign wall_y   = wall_y_q;
    assign PosX     = pos_x_q;
    assign PosY     = pos_y_q;
    assign dir      = dir_q;
    assign moving   = moving_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_pacman_move_ctrl.sv
// Bench for pacman_move_ctrl: directed frames, expected probes/moves queued,
// a negedge monitor pops and compares as the DUT produces them.
module tb_pacman_move_ctrl;

    logic       frame_clk = 1'b0;
    logic       Reset = 1'b1;
    logic       tick = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       wall_req;
    logic [9:0] wall_x;
    logic [9:0] wall_y;
    logic       wall_ack;
    logic       wall_blocked;
    logic [9:0] PosX;
    logic [9:0] PosY;
    logic [1:0] dir;
    logic       moving;
    logic       overrun;

    logic ack_r = 1'b0;
    logic ack_late = 1'b0;
    logic blk_r = 1'b0;

    assign wall_ack     = ack_r | ack_late;
    assign wall_blocked = blk_r;

    pacman_move_ctrl dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .tick         (tick),
        .keycode      (keycode),
        .wall_req     (wall_req),
        .wall_x       (wall_x),
        .wall_y       (wall_y),
        .wall_ack     (wall_ack),
        .wall_blocked (wall_blocked),
        .PosX         (PosX),
        .PosY         (PosY),
        .dir          (dir),
        .moving       (moving),
        .overrun      (overrun)
    );

    typedef struct {
        int x;
        int y;
    } probe_t;

    typedef struct {
        int x;
        int y;
        int d;
        int m;
        int cyc;
    } move_t;

    probe_t probe_q[$];
    move_t  move_q[$];
    int     ovr_q[$];
    bit     resp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 frame_clk = ~frame_clk;

    always @(posedge frame_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Wall unit model: acks in the first req cycle while responses are queued.
    initial forever begin
        @(negedge frame_clk);
        if (wall_req && resp_q.size() != 0) begin
            ack_r = 1'b1;
            blk_r = resp_q.pop_front();
        end else begin
            ack_r = 1'b0;
            blk_r = 1'b0;
        end
    end

    logic   req_prev = 1'b0;
    logic [9:0] px_prev = 10'd320;
    logic [9:0] py_prev = 10'd240;
    probe_t mp;
    move_t  mm;

    always @(negedge frame_clk) begin
        if (Reset) begin
            req_prev <= 1'b0;
            px_prev  <= PosX;
            py_prev  <= PosY;
        end else begin
            if (wall_req && !req_prev) begin
                chk("probe expected", int'(probe_q.size() != 0), 1);
                if (probe_q.size() != 0) begin
                    mp = probe_q.pop_front();
                    chk("probe x", int'(wall_x), mp.x);
                    chk("probe y", int'(wall_y), mp.y);
                end
            end
            if (PosX != px_prev || PosY != py_prev) begin
                chk("move expected", int'(move_q.size() != 0), 1);
                if (move_q.size() != 0) begin
                    mm = move_q.pop_front();
                    chk("move x", int'(PosX), mm.x);
                    chk("move y", int'(PosY), mm.y);
                    chk("move dir", int'(dir), mm.d);
                    chk("move moving", int'(moving), mm.m);
                    if (mm.cyc >= 0)
                        chk("move latency", cyc, mm.cyc);
                end
            end
            if (overrun) begin
                chk("overrun expected", int'(ovr_q.size() != 0), 1);
                if (ovr_q.size() != 0)
                    chk("overrun cycle", cyc, ovr_q.pop_front());
            end
            req_prev <= wall_req;
            px_prev  <= PosX;
            py_prev  <= PosY;
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge frame_clk);
    endtask

    task automatic do_tick(input logic [7:0] key, output int t0);
        @(negedge frame_clk);
        keycode = key;
        tick    = 1'b1;
        t0      = cyc + 1;
        @(negedge frame_clk);
        keycode = 8'h00;
        tick    = 1'b0;
    endtask

    task automatic push_probe(input int x, input int y);
        probe_t p;
        p.x = x;
        p.y = y;
        probe_q.push_back(p);
    endtask

    task automatic push_move(input int x, input int y, input int d,
                             input int m, input int c);
        move_t e;
        e.x = x;
        e.y = y;
        e.d = d;
        e.m = m;
        e.cyc = c;
        move_q.push_back(e);
    endtask

    task automatic wait_req(input int bound);
        int k;
        k = 0;
        while (!wall_req && k < bound) begin
            @(negedge frame_clk);
            k++;
        end
        chk("req seen in bound", int'(wall_req), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int hi;
        repeat (3) @(negedge frame_clk);
        chk("reset PosX", int'(PosX), 320);
        chk("reset PosY", int'(PosY), 240);
        chk("reset dir", int'(dir), 0);
        chk("reset moving", int'(moving), 0);
        chk("reset wall_req", int'(wall_req), 0);
        chk("reset overrun", int'(overrun), 0);
        Reset = 1'b0;

        // Idle tick with no key does nothing.
        do_tick(8'h00, t0);
        wait_n(6);
        chk("idle req", int'(wall_req), 0);
        chk("idle PosX", int'(PosX), 320);
        chk("idle PosY", int'(PosY), 240);
        chk("idle moving", int'(moving), 0);

        // Start moving right.
        resp_q.push_back(1'b0);
        do_tick(8'h07, t0);
        push_probe(321, 240);
        push_move(321, 240, 3, 1, t0 + 3);
        wait_n(6);

        // Turn up blocked, forward clear; the pending turn wins next frame.
        resp_q.push_back(1'b1);
        resp_q.push_back(1'b0);
        do_tick(8'h1a, t0);
        push_probe(321, 239);
        push_probe(322, 240);
        push_move(322, 240, 3, 1, t0 + 5);
        wait_n(8);
        chk("turn blocked dir", int'(dir), 3);
        resp_q.push_back(1'b0);
        do_tick(8'h00, t0);
        push_probe(322, 239);
        push_move(322, 239, 0, 1, t0 + 3);
        wait_n(6);

        // Turn left and run into the X_MIN edge.
        resp_q.push_back(1'b0);
        do_tick(8'h04, t0);
        push_probe(321, 239);
        push_move(321, 239, 1, 1, t0 + 3);
        wait_n(6);
        for (int x = 321; x > 4; x--) begin
            resp_q.push_back(1'b0);
            do_tick(8'h00, t0);
            push_probe(x - 1, 239);
            push_move(x - 1, 239, 1, 1, t0 + 3);
            wait_n(4);
        end
        do_tick(8'h00, t0);
        wait_n(4);
        chk("edge moving", int'(moving), 0);
        chk("edge PosX", int'(PosX), 4);
        chk("edge dir", int'(dir), 1);
        chk("edge req", int'(wall_req), 0);

        // No ack: request must stay up exactly TIMEOUT cycles.
        do_tick(8'h07, t0);
        push_probe(5, 239);
        wait_req(4);
        hi = 0;
        while (wall_req && hi < 40) begin
            @(negedge frame_clk);
            hi++;
        end
        chk("timeout req cycles", hi, 15);
        ack_late = 1'b1;
        @(negedge frame_clk);
        ack_late = 1'b0;
        wait_n(4);
        chk("late ack moving", int'(moving), 0);
        chk("late ack dir", int'(dir), 1);
        chk("late ack PosX", int'(PosX), 4);
        chk("late ack req", int'(wall_req), 0);

        // Pending right retries; reset lands mid-handshake.
        do_tick(8'h00, t0);
        push_probe(5, 239);
        wait_req(4);
        wait_n(3);
        #2 Reset = 1'b1;
        #1;
        chk("rst req drop", int'(wall_req), 0);
        chk("rst PosX", int'(PosX), 320);
        chk("rst PosY", int'(PosY), 240);
        chk("rst dir", int'(dir), 0);
        chk("rst moving", int'(moving), 0);
        chk("rst overrun", int'(overrun), 0);
        wait_n(2);
        Reset = 1'b0;

        // Overrun: tick while the forward probe is outstanding.
        resp_q.push_back(1'b0);
        do_tick(8'h07, t0);
        push_probe(321, 240);
        push_move(321, 240, 3, 1, t0 + 3);
        wait_n(4);
        do_tick(8'h00, t0);
        push_probe(322, 240);
        wait_req(4);
        wait_n(2);
        @(negedge frame_clk);
        ovr_q.push_back(cyc + 1);
        tick = 1'b1;
        @(negedge frame_clk);
        tick = 1'b0;
        resp_q.push_back(1'b0);
        push_move(322, 240, 3, 1, -1);
        wait_n(6);
        chk("final PosX", int'(PosX), 322);
        chk("final dir", int'(dir), 3);
        chk("final moving", int'(moving), 1);
        chk("probes left", probe_q.size(), 0);
        chk("moves left", move_q.size(), 0);
        chk("overruns left", ovr_q.size(), 0);
        chk("responses left", resp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
